// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller: IF/ID/EXE/MEM/WB state machine driving datapath enables and selects.
// Build option MCFSM_ILLEGAL_TRAP_EN: undefined opcodes halt and raise a sticky IllegalOp (otherwise they run as NOPs).
module multicycle_control_fsm #(
  parameter int         STATE_W = 3,
  parameter logic [5:0] OP_HALT = 6'b111111
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic               ExtSel,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [1:0]         PCSrc,
  output logic [STATE_W-1:0] State,
`ifdef MCFSM_ILLEGAL_TRAP_EN
  output logic               IllegalOp,
`endif
  output logic               Halted
);

  localparam logic [STATE_W-1:0] S_IF     = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_ID     = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_EXE_LS = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEM    = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_WB_L   = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_EXE_BR = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXE_AL = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_WB_AL  = STATE_W'(7);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  logic [STATE_W-1:0] state_q, state_d;
  logic               halted_q, halted_d;

  // Opcode classification
  logic op_r_form, op_i_form, op_alu;
  logic op_lw, op_sw, op_ls;
  logic op_beq, op_bne, op_br;
  logic op_j, op_jr, op_jal, op_halt;
  logic op_legal;
  logic br_taken;
  logic [2:0] alu_code;

  assign op_r_form = (Opcode == OP_ADD) || (Opcode == OP_SUB) ||
                     (Opcode == OP_AND) || (Opcode == OP_SLT);
  assign op_i_form = (Opcode == OP_ADDIU) || (Opcode == OP_ANDI) || (Opcode == OP_ORI);
  assign op_alu    = op_r_form || op_i_form;
  assign op_lw     = (Opcode == OP_LW);
  assign op_sw     = (Opcode == OP_SW);
  assign op_ls     = op_lw || op_sw;
  assign op_beq    = (Opcode == OP_BEQ);
  assign op_bne    = (Opcode == OP_BNE);
  assign op_br     = op_beq || op_bne;
  assign op_j      = (Opcode == OP_J);
  assign op_jr     = (Opcode == OP_JR);
  assign op_jal    = (Opcode == OP_JAL);
  assign op_halt   = (Opcode == OP_HALT);
  assign op_legal  = op_alu || op_ls || op_br || op_j || op_jr || op_jal || op_halt;
  assign br_taken  = (op_beq && Zero) || (op_bne && !Zero);

  always_comb begin
    case (Opcode)
      OP_SUB:          alu_code = ALU_SUB;
      OP_AND, OP_ANDI: alu_code = ALU_AND;
      OP_ORI:          alu_code = ALU_OR;
      OP_SLT:          alu_code = ALU_SLT;
      default:         alu_code = ALU_ADD;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_IF;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

`ifdef MCFSM_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign IllegalOp = illegal_q;
`endif

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
`ifdef MCFSM_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IF: state_d = halted_q ? S_IF : S_ID;
      S_ID: begin
        if (op_alu) begin
          state_d = S_EXE_AL;
        end else if (op_ls) begin
          state_d = S_EXE_LS;
        end else if (op_br) begin
          state_d = S_EXE_BR;
        end else begin
          state_d = S_IF;
        end
        if (op_halt) begin
          halted_d = 1'b1;
        end
`ifdef MCFSM_ILLEGAL_TRAP_EN
        if (!op_legal) begin
          halted_d  = 1'b1;
          illegal_d = 1'b1;
        end
`endif
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = op_lw ? S_WB_L : S_IF;
      S_WB_L:   state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  // Output logic
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = PC_NEXT;
    case (state_q)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        if (op_j || op_jal) begin
          PCWre = 1'b1;
          PCSrc = PC_JUMP;
        end else if (op_jr) begin
          PCWre = 1'b1;
          PCSrc = PC_RS;
        end
        // JAL links PC+4 into $31 in its decode cycle
        if (op_jal) begin
          RegWre    = 1'b1;
          RegDst    = 2'b00;
          WrRegDSrc = 1'b0;
        end
`ifndef MCFSM_ILLEGAL_TRAP_EN
        if (!op_legal) begin
          PCWre = 1'b1;
          PCSrc = PC_NEXT;
        end
`endif
      end
      S_EXE_AL: begin
        ALUOp   = alu_code;
        ALUSrcB = op_i_form;
        ExtSel  = (Opcode == OP_ADDIU);
      end
      S_WB_AL: begin
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b0;
        PCWre     = 1'b1;
        PCSrc     = PC_NEXT;
        RegDst    = op_r_form ? 2'b10 : 2'b01;
      end
      S_EXE_LS: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        ALUOp   = ALU_ADD;
      end
      S_MEM: begin
        if (op_lw) begin
          mRD = 1'b1;
        end else if (op_sw) begin
          mWR   = 1'b1;
          PCWre = 1'b1;
          PCSrc = PC_NEXT;
        end
      end
      S_WB_L: begin
        RegWre    = 1'b1;
        RegDst    = 2'b01;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b1;
        PCWre     = 1'b1;
        PCSrc     = PC_NEXT;
      end
      S_EXE_BR: begin
        ALUOp  = ALU_SUB;
        ExtSel = 1'b1;
        PCWre  = 1'b1;
        PCSrc  = br_taken ? PC_BRANCH : PC_NEXT;
      end
      default: ;
    endcase
    // Reset and halt both freeze every architectural write
    if (Reset || halted_q) begin
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      mWR    = 1'b0;
    end
  end

  assign State  = state_q;
  assign Halted = halted_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle MIPS datapath: a state machine over IF / ID / EXE / MEM / WB.
- Each cycle it drives the enables and selects for:
  - the PC and instruction register
  - the register file (RegWre, RegDst)
  - the ALU
  - data memory
- It guarantees at most one register-file write per instruction, only in its write-back slot.
- Sits between the instruction register (opcode source) and all datapath muxes.

Parameters:
- STATE_W, 3, width of State output (fixed encoding below)
- OP_HALT, 6'b111111, opcode that halts the CPU

Ports:
- CLK  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high; sampled on posedge CLK
- Opcode  input  6  IR[31:26], stable from ID onward
- Zero  input  1  ALU result == 0
- PCWre  output  1  PC load enable
- IRWre  output  1  instruction register load enable
- RegWre  output  1  register file write enable
- RegDst  output  2  00=$31, 01=rt, 10=rd
- WrRegDSrc  output  1  0=PC+4 (JAL), 1=DB bus
- ALUSrcA  output  1  1=shamt
- ALUSrcB  output  1  1=extended immediate
- ALUOp  output  3  000 add, 001 sub, 100 and, 011 or, 110 slt
- ExtSel  output  1  1=sign-extend, 0=zero-extend
- mRD  output  1  data memory read
- mWR  output  1  data memory write
- DBDataSrc  output  1  1=memory data, 0=ALU result
- PCSrc  output  2  00=PC+4, 01=branch target, 10=rs (JR), 11=jump target
- State  output  STATE_W  current state
- Halted  output  1  sticky halt flag

Behaviour:
- State encodings:
  - IF=000, ID=001, EXE_LS=010, MEM=011, WB_L=100, EXE_BR=101, EXE_AL=110, WB_AL=111
- State register and Halted are the only flops. All other outputs are combinational from (State, Opcode, Zero, Halted).
- Reset (synchronous):
  - Next State=IF, Halted=0.
  - While Reset is high, PCWre, RegWre, mWR and IRWre are forced to 0.
  - A Reset arriving mid-instruction abandons that instruction; no partial write occurs after the reset edge.
- Opcode map:
  - ADD 000000, SUB 000001, ADDIU 000010, AND 010000, ANDI 010001, ORI 010010, SLT 100110
  - SW 110000, LW 110001, BEQ 110100, BNE 110101
  - J 111000, JR 111001, JAL 111010, HALT=OP_HALT
- Transitions:
  - IF->ID always.
  - ID:
    - ALU ops -> EXE_AL
    - LW/SW -> EXE_LS
    - BEQ/BNE -> EXE_BR
    - J/JR/JAL/HALT -> IF
  - EXE_AL->WB_AL->IF. EXE_LS->MEM. MEM->WB_L for LW, IF for SW. WB_L->IF. EXE_BR->IF.
- Latency in cycles: J/JR/JAL/HALT 2, BEQ/BNE 3, SW 4, ALU ops 4, LW 5.
- Per-state outputs (default 0 unless listed):
  - IF: IRWre=1.
  - ID:
    - J/JAL: PCWre=1, PCSrc=11.
    - JR: PCWre=1, PCSrc=10.
    - JAL additionally: RegWre=1, RegDst=00, WrRegDSrc=0.
  - EXE_AL:
    - ALUOp per the map.
    - ALUSrcB=1 for ADDIU/ANDI/ORI.
    - ExtSel=1 for ADDIU, 0 for ANDI/ORI.
  - WB_AL:
    - RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00.
    - RegDst=10 for R-form (ADD/SUB/AND/SLT), 01 for immediate form.
  - EXE_LS: ALUSrcB=1, ExtSel=1, ALUOp=000.
  - MEM:
    - LW: mRD=1.
    - SW: mWR=1, PCWre=1, PCSrc=00.
  - WB_L: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1, PCWre=1, PCSrc=00.
  - EXE_BR:
    - ALUOp=001, ExtSel=1, PCWre=1.
    - PCSrc=01 if (BEQ & Zero) or (BNE & ~Zero), else 00.
- RegWre is asserted in at most one cycle per instruction. RegWre=1 implies State in {ID (JAL only), WB_AL, WB_L}.
- Halt:
  - HALT in ID sets Halted=1 and keeps PCWre=0.
  - Once Halted, the FSM stays in IF with IRWre=PCWre=RegWre=mWR=0 until Reset.
- Undefined opcodes: see Optional Feature.

Optional Feature:
- Macro name: MCFSM_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in ID sets Halted=1 and a sticky IllegalOp output (1 bit, port added).
  - No write enables fire.
  - Both flags are cleared only by Reset.
- Undefined (macro absent):
  - An undefined opcode is a NOP: ID asserts PCWre=1, PCSrc=00, next State=IF.
  - No IllegalOp port exists.

Test Plan:
- Reset high 2 cycles, then release -> State=000, Halted=0, PCWre=RegWre=mWR=0 during reset; IRWre=1 in the first IF.
- ADD (000000) -> State sequence 000,001,110,111,000; RegWre=1 only in 111 with RegDst=10; ALUOp=000 in 110.
- LW (110001) then SW (110000) -> LW visits 000,001,010,011,100 with mRD=1 in 011 and RegWre=1, RegDst=01, DBDataSrc=1 in 100; SW has mWR=1 in 011, returns to 000, RegWre never 1.
- BEQ with Zero=1, then BNE with Zero=1 -> BEQ: PCSrc=01 in 101. BNE: PCSrc=00 in 101. Both return to 000 after 3 cycles.
- JAL (111010) -> in 001: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1; next State=000.
- HALT (111111), then assert Reset mid-stream during a subsequent ADD's EXE_AL -> Halted=1 and all enables 0 until Reset; after Reset the pending write never occurs and State=000.
